// File: rtl/gon_bus.sv
// Gather bus: returns one value per tag from the lowest-indexed PE slave whose scanned ID
// matches and whose data is valid. Slave IDs are loaded through a serial scan chain.
module gon_bus #(
  parameter int unsigned SLAVE_NUMS = 14,
  parameter int unsigned ID_LEN     = 4,
  parameter int unsigned VALUE_LEN  = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              set_id,
  input  logic [ID_LEN-1:0]                 id_scan_in,
  output logic [ID_LEN-1:0]                 id_scan_out,
  input  logic                              tag_valid,
  input  logic [ID_LEN-1:0]                 tag_in,
  output logic                              tag_ready,
  input  logic [SLAVE_NUMS*(VALUE_LEN+1)-1:0] slave_enable_data,
  output logic [SLAVE_NUMS-1:0]             slave_ready,
  output logic                              out_valid,
  output logic [VALUE_LEN-1:0]              out_value,
  input  logic                              out_ready
);

  localparam int unsigned SlotW = VALUE_LEN + 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSearch = 2'd1;
  localparam logic [1:0] StSend   = 2'd2;

  logic [ID_LEN-1:0]    id_q [SLAVE_NUMS];
  logic [1:0]           state_q, state_d;
  logic [ID_LEN-1:0]    tag_q, tag_d;
  logic [VALUE_LEN-1:0] out_value_q, out_value_d;
  logic                 out_valid_q, out_valid_d;

  logic [SLAVE_NUMS-1:0] match;
  logic [SLAVE_NUMS-1:0] sel_onehot;
  logic [VALUE_LEN-1:0]  sel_data;
  logic                  hit;

  // Scan chain shifts regardless of FSM state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < int'(SLAVE_NUMS); k++) begin
        id_q[k] <= '0;
      end
    end else if (set_id) begin
      id_q[0] <= id_scan_in;
      for (int k = 1; k < int'(SLAVE_NUMS); k++) begin
        id_q[k] <= id_q[k-1];
      end
    end
  end

  assign id_scan_out = id_q[SLAVE_NUMS-1];

  always_comb begin
    match = '0;
    for (int k = 0; k < int'(SLAVE_NUMS); k++) begin
      match[k] = (id_q[k] == tag_q) && slave_enable_data[k*SlotW + VALUE_LEN] && !set_id;
    end
  end

  // Lowest matching index wins so duplicate IDs drain in slave order.
  always_comb begin
    hit        = 1'b0;
    sel_onehot = '0;
    sel_data   = '0;
    for (int k = 0; k < int'(SLAVE_NUMS); k++) begin
      if (match[k] && !hit) begin
        hit           = 1'b1;
        sel_onehot[k] = 1'b1;
        sel_data      = slave_enable_data[k*SlotW +: VALUE_LEN];
      end
    end
  end

  assign tag_ready   = rst && (state_q == StIdle) && !set_id;
  assign slave_ready = (rst && (state_q == StSearch) && hit) ? sel_onehot : '0;
  assign out_valid   = out_valid_q;
  assign out_value   = out_value_q;

  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    out_value_d = out_value_q;
    out_valid_d = out_valid_q;
    case (state_q)
      StIdle: begin
        if (tag_valid && tag_ready) begin
          tag_d   = tag_in;
          state_d = StSearch;
        end
      end
      StSearch: begin
        if (hit) begin
          out_value_d = sel_data;
          out_valid_d = 1'b1;
          state_d     = StSend;
        end
      end
      StSend: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      tag_q       <= '0;
      out_value_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      out_value_q <= out_value_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_gon_bus.sv
// Bench for gon_bus: behavioural slave row with pop-on-handshake, scoreboard of expected
// gathered values and selected slaves, table-driven gathers plus multi-cycle corner cases.
module tb_gon_bus;

  localparam int N  = 14;
  localparam int IW = 4;
  localparam int VW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            set_id;
  logic [IW-1:0]   id_scan_in;
  logic [IW-1:0]   id_scan_out;
  logic            tag_valid;
  logic [IW-1:0]   tag_in;
  logic            tag_ready;
  logic [N*(VW+1)-1:0] slave_enable_data;
  logic [N-1:0]    slave_ready;
  logic            out_valid;
  logic [VW-1:0]   out_value;
  logic            out_ready;

  gon_bus #(.SLAVE_NUMS(N), .ID_LEN(IW), .VALUE_LEN(VW)) dut (
    .clk               (clk),
    .rst               (rst),
    .set_id            (set_id),
    .id_scan_in        (id_scan_in),
    .id_scan_out       (id_scan_out),
    .tag_valid         (tag_valid),
    .tag_in            (tag_in),
    .tag_ready         (tag_ready),
    .slave_enable_data (slave_enable_data),
    .slave_ready       (slave_ready),
    .out_valid         (out_valid),
    .out_value         (out_value),
    .out_ready         (out_ready)
  );

  always #5 clk = ~clk;

  // Slave row model
  logic [N-1:0]  sv;
  logic [VW-1:0] sd [N];
  always_comb begin
    slave_enable_data = '0;
    for (int k = 0; k < N; k++) slave_enable_data[k*(VW+1) +: VW+1] = {sv[k], sd[k]};
  end

  int n_chk = 0, n_pass = 0;
  int cyc_n = 0, s_cyc = 0, done_cnt = 0;
  int acc_cyc, pop_cyc, first_ov;
  logic [VW-1:0] exp_dat [$];
  int            exp_slv [$];
  logic [IW-1:0] m_id [N];

  logic [N-1:0]  s_slave_ready;
  logic          s_tag_ready, s_out_valid;
  logic [VW-1:0] s_out_value;
  logic [IW-1:0] s_id_scan_out;

  typedef struct {
    logic [IW-1:0] tag;
    logic [N-1:0]  mask;
    int            slv;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock: sample at negedge, score, then apply slave pops after the edge.
  task automatic cyc();
    logic [N-1:0] popm;
    logic [N-1:0] oh;
    @(negedge clk);
    s_cyc         = cyc_n;
    s_slave_ready = slave_ready;
    s_tag_ready   = tag_ready;
    s_out_valid   = out_valid;
    s_out_value   = out_value;
    s_id_scan_out = id_scan_out;
    if (|s_slave_ready) begin
      pop_cyc = s_cyc;
      if (exp_slv.size() == 0) chk("unexpected pop", 64'(s_slave_ready), 64'd0);
      else begin
        oh = '0;
        oh[exp_slv.pop_front()] = 1'b1;
        chk("pop select", 64'(s_slave_ready), 64'(oh));
      end
    end
    if (s_out_valid && first_ov < 0) first_ov = s_cyc;
    if (s_out_valid && out_ready) begin
      if (exp_dat.size() == 0) chk("unexpected output", 64'(s_out_value), 64'd0);
      else chk("gather data", 64'(s_out_value), 64'(exp_dat.pop_front()));
      done_cnt++;
    end
    popm = s_slave_ready & sv;
    @(posedge clk);
    #1;
    sv = sv & ~popm;
    cyc_n++;
  endtask

  task automatic scan(input logic [IW-1:0] want [N]);
    set_id = 1'b1;
    for (int i = 0; i < N; i++) begin
      id_scan_in = want[N-1-i];
      cyc();
      chk("scan out", 64'(s_id_scan_out), 64'(m_id[N-1]));
      chk("tag_ready while scanning", 64'(s_tag_ready), 64'd0);
      for (int k = N - 1; k > 0; k--) m_id[k] = m_id[k-1];
      m_id[0] = id_scan_in;
    end
    set_id = 1'b0;
    id_scan_in = '0;
  endtask

  task automatic issue(input logic [IW-1:0] tag, input int slv);
    bit ok = 0;
    exp_dat.push_back(sd[slv]);
    exp_slv.push_back(slv);
    pop_cyc = -1;
    first_ov = -1;
    tag_valid = 1'b1;
    tag_in = tag;
    for (int i = 0; i < 10 && !ok; i++) begin
      cyc();
      if (s_tag_ready) begin
        ok = 1;
        acc_cyc = s_cyc;
      end
    end
    tag_valid = 1'b0;
    tag_in = ~tag;  // must not disturb the pending request
    if (!ok) begin
      chk("tag accept timeout", 64'd0, 64'd1);
      exp_dat.delete();
      exp_slv.delete();
    end
  endtask

  task automatic wait_done(input int budget);
    int start = done_cnt;
    for (int i = 0; i < budget && done_cnt == start; i++) cyc();
    if (done_cnt == start) begin
      chk("gather timeout", 64'd0, 64'd1);
      exp_dat.delete();
      exp_slv.delete();
    end
  endtask

  task automatic wait_out_valid();
    for (int i = 0; i < 10 && !s_out_valid; i++) cyc();
    chk("out_valid reached", 64'(s_out_valid), 64'd1);
  endtask

  initial begin
    logic [IW-1:0] ids [N];
    logic [N-1:0]  left;
    rst = 1'b0; set_id = 1'b0; id_scan_in = '0; tag_valid = 1'b0; tag_in = '0;
    out_ready = 1'b1; sv = '0;
    for (int k = 0; k < N; k++) begin
      sd[k] = 32'hC0DE_0000 + 32'(k);
      m_id[k] = '0;
    end
    s_out_valid = 1'b0;

    #3;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_value", 64'(out_value), 64'd0);
    chk("reset tag_ready", 64'(tag_ready), 64'd0);
    chk("reset slave_ready", 64'(slave_ready), 64'd0);
    chk("reset id_scan_out", 64'(id_scan_out), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    cyc();
    chk("idle tag_ready", 64'(s_tag_ready), 64'd1);

    // Chain 6..0,6..0: slot k holds k for k<7, k-7 above.
    for (int k = 0; k < N; k++) ids[k] = IW'(k < 7 ? k : k - 7);
    scan(ids);
    cyc();
    chk("scan out after load", 64'(s_id_scan_out), 64'd6);

    // Single gather latency; slave 10 shares ID 3 but stays invalid.
    sd[3] = 32'h1234_5678;
    sv = '0;
    sv[3] = 1'b1;
    issue(4'd3, 3);
    wait_done(10);
    chk("pop latency", 64'(pop_cyc - acc_cyc), 64'd1);
    chk("out_valid latency", 64'(first_ov - acc_cyc), 64'd2);

    tbl[0] = '{tag: 4'd0, mask: 14'b00_0000_1000_0001, slv: 0};
    tbl[1] = '{tag: 4'd6, mask: 14'b10_0000_0000_0000, slv: 13};
    tbl[2] = '{tag: 4'd2, mask: 14'b00_0010_0010_0100, slv: 2};
    tbl[3] = '{tag: 4'd2, mask: 14'b00_0010_0000_0000, slv: 9};
    tbl[4] = '{tag: 4'd5, mask: 14'b01_0000_0000_1000, slv: 12};
    tbl[5] = '{tag: 4'd1, mask: 14'b00_0001_0000_0010, slv: 1};
    for (int i = 0; i < 6; i++) begin
      sv = tbl[i].mask;
      issue(tbl[i].tag, tbl[i].slv);
      wait_done(10);
      left = tbl[i].mask;
      left[tbl[i].slv] = 1'b0;
      chk("table valids left", 64'(sv), 64'(left));
    end

    // Late data: nothing valid for ID 4 during five SEARCH cycles.
    sv = '0;
    issue(4'd4, 4);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("late slave_ready", 64'(s_slave_ready), 64'd0);
      chk("late tag_ready", 64'(s_tag_ready), 64'd0);
    end
    sv[4] = 1'b1;
    cyc();
    chk("late pop cycle", 64'(pop_cyc), 64'(s_cyc));
    wait_done(10);

    // Backpressure in SEND.
    out_ready = 1'b0;
    sv = '0;
    sv[6] = 1'b1;
    issue(4'd6, 6);
    wait_out_valid();
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("bp out_valid", 64'(s_out_valid), 64'd1);
      chk("bp out_value", 64'(s_out_value), 64'(sd[6]));
      chk("bp tag_ready", 64'(s_tag_ready), 64'd0);
    end
    out_ready = 1'b1;
    cyc();
    cyc();
    chk("bp back to idle", 64'(s_tag_ready), 64'd1);
    chk("bp out_valid low", 64'(s_out_valid), 64'd0);

    // Duplicate ID 5 on slaves 2 and 9, all others ID 15.
    for (int k = 0; k < N; k++) ids[k] = (k == 2 || k == 9) ? 4'd5 : 4'd15;
    scan(ids);
    sd[2] = 32'hDDDD_0002;
    sd[9] = 32'hDDDD_0009;
    sv = '0;
    sv[2] = 1'b1;
    sv[9] = 1'b1;
    issue(4'd5, 2);
    wait_done(10);
    chk("dup slave 9 still valid", 64'(sv), 64'(14'b00_0010_0000_0000));
    issue(4'd5, 9);
    wait_done(10);

    // Async reset while in SEND.
    out_ready = 1'b0;
    sv = '0;
    sv[0] = 1'b1;
    issue(4'd15, 0);
    wait_out_valid();
    #2 rst = 1'b0;
    #1;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst tag_ready", 64'(tag_ready), 64'd0);
    chk("rst slave_ready", 64'(slave_ready), 64'd0);
    chk("rst id_scan_out", 64'(id_scan_out), 64'd0);
    exp_dat.delete();
    exp_slv.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    out_ready = 1'b1;
    cyc();
    chk("post-rst tag_ready", 64'(s_tag_ready), 64'd1);
    chk("post-rst out_valid", 64'(s_out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
